// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS token constants, FSM state type and default limits
package tmds_pkg;

  localparam logic [9:0] TOK_C00 = 10'h354;
  localparam logic [9:0] TOK_C01 = 10'h0AB;
  localparam logic [9:0] TOK_C10 = 10'h154;
  localparam logic [9:0] TOK_C11 = 10'h2AB;

  localparam int DEF_LOCK_RUN   = 16;
  localparam int DEF_SEARCH_LEN = 4096;
  localparam int DEF_SLIP_WAIT  = 8;
  localparam int DEF_LOSS_LEN   = 65536;

  // Token run that keeps an established lock alive.
  localparam int HOLD_RUN = 8;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } tmds_state_e;

  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// rtl/tmds_word_decode.sv - classifies one TMDS word as control token or data and decodes it
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word_i,
  output logic       is_token_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  logic [7:0] q;

  always_comb begin
    is_token_o = 1'b1;
    ctrl_o     = 2'b00;
    case (word_i)
      TOK_C00: ctrl_o = 2'b00;
      TOK_C01: ctrl_o = 2'b01;
      TOK_C10: ctrl_o = 2'b10;
      TOK_C11: ctrl_o = 2'b11;
      default: is_token_o = 1'b0;
    endcase
  end

  // Bit 9 undoes DC-balance inversion; bit 8 selects XOR or XNOR chaining.
  assign q      = word_i[9] ? ~word_i[7:0] : word_i[7:0];
  assign data_o = {word_i[8] ? (q[7:1] ^ q[6:0]) : ~(q[7:1] ^ q[6:0]), q[0]};

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS channel decoder with word-alignment FSM driving deserializer bitslip
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_RUN   = DEF_LOCK_RUN,
  parameter int SEARCH_LEN = DEF_SEARCH_LEN,
  parameter int SLIP_WAIT  = DEF_SLIP_WAIT,
  parameter int LOSS_LEN   = DEF_LOSS_LEN
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic [9:0] raw_word,
  output logic       bitslip,
  output logic       aligned,
  output logic [7:0] dout,
  output logic       de,
  output logic       c0,
  output logic       c1
);

  localparam int RUN_W  = (cnt_width(LOCK_RUN) > 4) ? cnt_width(LOCK_RUN) : 4;
  localparam int SRCH_W = cnt_width(SEARCH_LEN);
  localparam int WAIT_W = cnt_width(SLIP_WAIT);
  localparam int LOSS_W = cnt_width(LOSS_LEN);

  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_RUN - 1);
  localparam logic [RUN_W-1:0]  RUN_HOLD  = RUN_W'(HOLD_RUN - 1);
  localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_LEN - 1);

  tmds_state_e       state_q, state_d;
  logic [9:0]        raw_q;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [SRCH_W-1:0] srch_q, srch_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              aligned_q;
  logic [7:0]        dout_q;
  logic              de_q;
  logic [1:0]        ctrl_q;

  logic              tok;
  logic [1:0]        tok_ctrl;
  logic [7:0]        data_byte;
  logic              lock_hit;
  logic              hold_hit;
  logic [RUN_W-1:0]  run_inc;

  tmds_word_decode u_word_decode (
    .word_i     (raw_q),
    .is_token_o (tok),
    .ctrl_o     (tok_ctrl),
    .data_o     (data_byte)
  );

  // The FSM watches the registered word, the same one that feeds the output stage.
  assign run_inc  = (run_q == '1) ? run_q : run_q + RUN_W'(1);
  assign lock_hit = tok && (run_q == RUN_LOCK);
  assign hold_hit = tok && (run_q >= RUN_HOLD);

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (lock_hit) begin
          state_d = ST_LOCKED;
        end else if (srch_q == SRCH_LAST) begin
          state_d = ST_SLIP;
        end
      end
      ST_SLIP:   state_d = ST_WAIT;
      ST_WAIT:   if (wait_q == WAIT_LAST) state_d = ST_SEARCH;
      ST_LOCKED: if (!hold_hit && (loss_q == LOSS_LAST)) state_d = ST_SEARCH;
      default:   state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    bitslip = (state_q == ST_SLIP);
  end

  // Every counter restarts from zero whenever the state changes.
  always_comb begin
    run_d  = '0;
    srch_d = '0;
    wait_d = '0;
    loss_d = '0;
    if (state_d == state_q) begin
      case (state_q)
        ST_SEARCH: begin
          run_d  = tok ? run_inc : '0;
          srch_d = (srch_q == '1) ? srch_q : srch_q + SRCH_W'(1);
        end
        ST_WAIT: wait_d = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
        ST_LOCKED: begin
          run_d  = tok ? run_inc : '0;
          loss_d = hold_hit ? '0 : ((loss_q == '1) ? loss_q : loss_q + LOSS_W'(1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      run_q  <= '0;
      srch_q <= '0;
      wait_q <= '0;
      loss_q <= '0;
    end else begin
      run_q  <= run_d;
      srch_q <= srch_d;
      wait_q <= wait_d;
      loss_q <= loss_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      raw_q     <= '0;
      aligned_q <= 1'b0;
      dout_q    <= '0;
      de_q      <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      raw_q     <= raw_word;
      aligned_q <= (state_q == ST_LOCKED);
      if (!aligned_q) begin
        dout_q <= '0;
        de_q   <= 1'b0;
        ctrl_q <= '0;
      end else if (tok) begin
        dout_q <= '0;
        de_q   <= 1'b0;
        ctrl_q <= tok_ctrl;
      end else begin
        dout_q <= data_byte;
        de_q   <= 1'b1;
      end
    end
  end

  assign aligned = aligned_q;
  assign dout    = dout_q;
  assign de      = de_q;
  assign c0      = ctrl_q[0];
  assign c1      = ctrl_q[1];

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - randomized self-checking bench for tmds_decoder with a behavioural channel model
module tb_tmds_decoder;

  localparam int LR = 16;
  localparam int SL = 64;
  localparam int SW = 8;
  localparam int LL = 256;
  localparam int P  = SL + 1 + SW;

  localparam logic [9:0] T00 = 10'h354;
  localparam logic [9:0] T01 = 10'h0AB;
  localparam logic [9:0] T10 = 10'h154;
  localparam logic [9:0] T11 = 10'h2AB;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] raw_word = '0;
  logic       bitslip, aligned, de, c0, c1;
  logic [7:0] dout;

  always #5 pclk = ~pclk;

  tmds_decoder #(
    .LOCK_RUN   (LR),
    .SEARCH_LEN (SL),
    .SLIP_WAIT  (SW),
    .LOSS_LEN   (LL)
  ) dut (
    .pclk     (pclk),
    .reset    (reset),
    .raw_word (raw_word),
    .bitslip  (bitslip),
    .aligned  (aligned),
    .dout     (dout),
    .de       (de),
    .c0       (c0),
    .c1       (c1)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0=search 1=slip 2=wait 3=locked, plain integer counters.
  int         m_mode, m_run, m_tmr;
  logic [9:0] m_raw;
  logic       m_al, m_de, m_bs;
  logic [7:0] m_dout;
  logic [1:0] m_c;
  int         off = 0;
  string      phase = "reset";

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [9:0] r = w;
    for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  function automatic bit classify(input logic [9:0] w, output logic [1:0] c);
    c = 2'b00;
    if (w == T00) begin c = 2'b00; return 1'b1; end
    if (w == T01) begin c = 2'b01; return 1'b1; end
    if (w == T10) begin c = 2'b10; return 1'b1; end
    if (w == T11) begin c = 2'b11; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic [7:0] spec_decode(input logic [9:0] w);
    logic [7:0] q = w[9] ? ~w[7:0] : w[7:0];
    logic [7:0] d;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // Transmit-side encoder (transition minimisation, optional inversion).
  function automatic logic [9:0] encode(input logic [7:0] d, input bit inv);
    int         n1 = 0;
    bit         use_xnor;
    logic [7:0] qm;
    for (int i = 0; i < 8; i++) n1 += d[i];
    use_xnor = (n1 > 4) || (n1 == 4 && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    return {inv, ~use_xnor, inv ? ~qm : qm};
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    logic [1:0] c;
    do w = encode(8'($urandom), 1'($urandom)); while (classify(w, c));
    return w;
  endfunction

  task automatic model_step(input logic [9:0] w, input bit rst);
    bit         t;
    logic [1:0] c;
    int         cnt;
    if (rst) begin
      m_mode = 0; m_run = 0; m_tmr = 0; m_raw = '0;
      m_al = 0; m_de = 0; m_dout = '0; m_c = '0; m_bs = 0;
      return;
    end
    t = classify(m_raw, c);
    if (!m_al) begin
      m_de = 0; m_dout = '0; m_c = '0;
    end else if (t) begin
      m_de = 0; m_dout = '0; m_c = c;
    end else begin
      m_de = 1; m_dout = spec_decode(m_raw);
    end
    m_al = (m_mode == 3);
    cnt  = t ? m_run + 1 : 0;
    case (m_mode)
      0: if (cnt >= LR) begin m_mode = 3; m_run = 0; m_tmr = 0; end
         else if (m_tmr == SL - 1) begin m_mode = 1; m_run = 0; m_tmr = 0; end
         else begin m_run = cnt; m_tmr++; end
      1: begin m_mode = 2; m_tmr = 0; end
      2: if (m_tmr == SW - 1) begin m_mode = 0; m_run = 0; m_tmr = 0; end
         else m_tmr++;
      default: begin
        m_run = cnt;
        if (cnt >= 8) m_tmr = 0;
        else if (m_tmr == LL - 1) begin m_mode = 0; m_run = 0; m_tmr = 0; end
        else m_tmr++;
      end
    endcase
    m_bs  = (m_mode == 1);
    m_raw = w;
  endtask

  // One clock: drive the rotated word, advance the model, compare all outputs.
  task automatic tick(input logic [9:0] w, input bit rst);
    raw_word = rotl(w, off);
    reset    = rst;
    @(posedge pclk);
    model_step(raw_word, rst);
    @(negedge pclk);
    check(phase, {19'd0, aligned, bitslip, de, c1, c0, dout},
          {19'd0, m_al, m_bs, m_de, m_c, m_dout});
    if (m_bs) off = (off == 0) ? 9 : off - 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_al, t_lo, bs_cnt, burst;
    int pulses[$];
    logic [9:0] w;

    @(negedge pclk);
    repeat (3) tick('0, 1'b1);
    check("reset_outputs", {aligned, bitslip, de, c1, c0, dout}, '0);

    phase = "lock"; t_al = -1; bs_cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      tick(T00, 1'b0);
      if (aligned && t_al < 0) t_al = k;
      bs_cnt += bitslip;
    end
    check("lock_latency", t_al, LR + 2);
    check("lock_no_bitslip", bs_cnt, 0);
    check("lock_ctrl", {c1, c0, de}, 3'b000);

    phase = "ctl_data";
    tick(T01, 1'b0);
    tick(encode(8'hA5, 1'b0), 1'b0);
    check("c_after_0ab", {c1, c0, de}, 3'b010);
    tick(encode(8'h3C, 1'b1), 1'b0);
    check("dout_a5", {de, dout}, {1'b1, 8'hA5});
    check("c_held", {c1, c0}, 2'b01);
    tick(T00, 1'b0);
    check("dout_3c_inverted", {de, dout}, {1'b1, 8'h3C});

    phase = "random"; burst = 0;
    for (int k = 0; k < 2500; k++) begin
      if (burst > 0) begin
        burst--;
        w = rotl(T00, 0);
        case ($urandom_range(0, 3))
          0: w = T00;
          1: w = T01;
          2: w = T10;
          default: w = T11;
        endcase
      end else if ($urandom_range(0, 15) == 0) begin
        burst = $urandom_range(1, 24);
        w = T11;
      end else begin
        w = rand_data();
      end
      tick(w, ($urandom_range(0, 799) == 0));
    end

    phase = "near_miss"; off = 0; t_al = -1;
    tick('0, 1'b1);
    for (int k = 1; k <= 36; k++) begin
      tick((k == 16) ? encode(8'h5A, 1'b0) : T00, 1'b0);
      if (aligned && t_al < 0) t_al = k;
    end
    check("near_miss_lock", t_al, 15 + 1 + LR + 2);

    phase = "loss"; t_lo = -1;
    for (int k = 1; k <= 20 + LL + 10; k++) begin
      tick((k <= 20) ? T10 : rand_data(), 1'b0);
      if (!aligned && t_lo < 0) t_lo = k;
    end
    check("loss_drop_time", t_lo, 20 + LL + 2);
    check("loss_outputs", {aligned, de, dout}, '0);

    phase = "bitslip"; off = 3; t_al = -1;
    tick('0, 1'b1);
    for (int k = 1; k <= 4 * P + 40 && t_al < 0; k++) begin
      tick(T00, 1'b0);
      if (bitslip) pulses.push_back(k);
      if (aligned) t_al = k;
    end
    check("slip_pulse_count", pulses.size(), 3);
    if (pulses.size() > 0) check("slip_first", pulses[0], SL);
    for (int i = 1; i < pulses.size(); i++) check("slip_interval", pulses[i] - pulses[i-1], P);
    check("slip_lock_time", t_al, 3 * P + 17);
    check("slip_offset_restored", off, 0);

    phase = "rst_slip"; off = 3; bs_cnt = 0;
    tick('0, 1'b1);
    for (int k = 0; k < SL + 5 && !bitslip; k++) tick(T00, 1'b0);
    check("reached_slip", bitslip, 1'b1);
    tick(T00, 1'b1);
    check("rst_in_slip", {aligned, bitslip, de, c1, c0, dout}, '0);
    for (int k = 0; k < 5; k++) begin
      tick(T00, 1'b0);
      bs_cnt += bitslip;
    end
    check("no_pending_slip", bs_cnt, 0);

    phase = "rst_locked"; off = 0;
    tick('0, 1'b1);
    repeat (20) tick(T00, 1'b0);
    tick(T11, 1'b0);
    tick(encode(8'hFF, 1'b0), 1'b0);
    tick(encode(8'h01, 1'b0), 1'b0);
    check("locked_before_rst", {aligned, de, c1, c0, dout}, {4'b1111, 8'hFF});
    tick(T00, 1'b1);
    check("rst_in_locked", {aligned, bitslip, de, c1, c0, dout}, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
